// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and default width for the EXE-stage
// iterative multiply/divide unit (exe_muldiv_unit).
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign correction of the unsigned magnitude results: negates the
// 2*WIDTH product, or the quotient and remainder independently for divides.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             is_div,
  input  logic             neg_res,
  input  logic             neg_rem,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_neg;
  logic [WIDTH-1:0]   rem_neg;

  assign prod     = {acc_hi, acc_lo};
  assign prod_neg = -prod;
  assign quo_neg  = -acc_lo;
  assign rem_neg  = -acc_hi;

  // Divide: LO holds the quotient, HI the remainder (takes the dividend's sign).
  assign res_lo = is_div ? (neg_res ? quo_neg : acc_lo)
                         : (neg_res ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0]);
  assign res_hi = is_div ? (neg_rem ? rem_neg : acc_hi)
                         : (neg_res ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH]);

endmodule

// File: rtl/exe_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; one result bit per cycle.
// Optional macro MULDIV_DIVZERO_FLAG_EN adds the div_zero status output.
module exe_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush_i,
  input  logic             hilo_rd_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
`ifdef MULDIV_DIVZERO_FLAG_EN
  output logic             div_zero,
`endif
  output logic             busy,
  output logic             done,
  output logic             stall_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] opnd;     // multiplicand (MUL) or divisor (DIV) magnitude
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier then product low half / quotient
  logic             neg_res;
  logic             neg_rem;
  logic             div_q;

  logic             is_div;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             div_by_zero;
  logic             accept;
  logic             last;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign is_div      = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign is_signed   = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_neg       = is_signed & src_a[WIDTH-1];
  assign b_neg       = is_signed & src_b[WIDTH-1];
  assign mag_a       = a_neg ? -src_a : src_a;
  assign mag_b       = b_neg ? -src_b : src_b;
  assign div_by_zero = is_div && (src_b == '0);

  assign busy      = (state == MUL) || (state == DIV) || (state == FIX);
  assign done      = (state == DONE);
  assign stall_out = busy & (hilo_rd_i | start_i | hi_we_i | lo_we_i);
  assign accept    = start_i & ~flush_i & ((state == IDLE) || (state == DONE));
  assign last      = (count == CNT_W'(WIDTH - 1));

  // Shift-add: {acc_hi, acc_lo} shifts right one bit per step after the add.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  // Restoring divide: bring in the next dividend bit, subtract if it fits.
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, opnd});
  assign div_diff  = div_trial[WIDTH-1:0] - opnd;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_div  (div_q),
    .neg_res (neg_res),
    .neg_rem (neg_rem),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .res_hi  (fix_hi),
    .res_lo  (fix_lo)
  );

  // NOTE: every sequential state uses non-blocking <= so all flops sample
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept) begin
            count   <= '0;
            acc_hi  <= '0;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div_q   <= is_div;
            if (is_div) begin
              opnd   <= mag_b;
              acc_lo <= mag_a;
              state  <= div_by_zero ? DONE : DIV;
            end else begin
              opnd   <= mag_a;
              acc_lo <= mag_b;
              state  <= MUL;
            end
          end
        end
        MUL: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            count  <= count + 1'b1;
            if (last) state <= FIX;
          end
        end
        DIV: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            acc_hi <= div_ge ? div_diff : div_trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            count  <= count + 1'b1;
            if (last) state <= FIX;
          end
        end
        FIX:     state <= flush_i ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // A result landing on the same edge as an MT write wins; MT writes only
  // apply while no operation is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if ((state == FIX) && !flush_i) begin
      hi_out <= fix_hi;
      lo_out <= fix_lo;
    end else if (accept && div_by_zero) begin
      hi_out <= src_a;
      lo_out <= '1;
    end else if (!busy) begin
      if (hi_we_i) hi_out <= wdata_i;
      if (lo_we_i) lo_out <= wdata_i;
    end
  end

`ifdef MULDIV_DIVZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_zero <= 1'b0;
    end else if (accept) begin
      div_zero <= div_by_zero;
    end
  end
`endif

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Iterative multiply/divide unit for the EXE stage; it consumes the ID/EXE register operands (readData1Out/readData2Out) when a MULT/MULTU/DIV/DIVU is in EXE.
- Holds the architectural HI/LO registers and drives a stall request back to the hazard logic while a HI/LO consumer or a new mul/div must wait.
- Sits beside the ALU; results are read through MFHI/MFLO via hi_out/lo_out.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  mul/div instruction valid in EXE this cycle.
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  input  WIDTH  rs operand (multiplicand or dividend).
- src_b  input  WIDTH  rt operand (multiplier or divisor).
- flush_i  input  1  abort the in-flight operation (branch or exception squash).
- hilo_rd_i  input  1  MFHI/MFLO in EXE this cycle.
- hi_we_i  input  1  MTHI write.
- lo_we_i  input  1  MTLO write.
- wdata_i  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; the new HI/LO are visible this cycle.
- stall_out  output  1  equals busy & (hilo_rd_i | start_i | hi_we_i | lo_we_i).
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; hi_out, lo_out, all internal accumulators and the counter = 0; busy=0, done=0.
- States and transitions:
  - IDLE: start_i=1 captures operand magnitudes (absolute values for MULT/DIV) and the result sign flags.
    - If op is a divide and src_b==0, go to DONE.
    - Otherwise go to MUL or DIV with count=0.
  - MUL: one shift-add step per cycle, WIDTH cycles, then FIX.
  - DIV: one restoring shift-subtract step per cycle, WIDTH cycles, then FIX.
  - FIX: apply signs, write HI/LO, go to DONE.
    - MULT: negate the 2*WIDTH product if the operand signs differ.
    - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - DONE: done=1 and busy=0; return to IDLE. A start_i in DONE is accepted exactly as in IDLE.
- Latency (start edge = cycle 0): busy=1 in cycles 1..33; FIX is cycle 33; done=1 and HI/LO updated in cycle 34.
- Divide-by-zero: DONE in cycle 1 with HI=src_a and LO=all ones, for both DIV and DIVU.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- busy is high in MUL, DIV and FIX only.
- start_i while busy: ignored. stall_out holds the instruction until DONE, where it is accepted.
- flush_i while busy: next state IDLE; HI/LO unchanged; no done pulse. flush_i in IDLE or DONE also kills a simultaneous start_i.
- MTHI/MTLO: applied at the edge only when not busy.
  - In DONE, the MT write takes priority over nothing: the FIX result has already been written.
  - MT write together with start_i in IDLE: the write applies, and the later result overwrites it.
- hi_out/lo_out are direct register outputs. No forwarding of in-flight results.

Optional Feature:
- Macro: MULDIV_DIVZERO_FLAG_EN.
- Defined: adds output div_zero (1 bit).
  - Set together with done for a divide whose divisor was 0.
  - Cleared on the next accepted start_i or by reset.
- Undefined: port absent; divide-by-zero results unchanged.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, MUL, DIV, FIX, DONE);
  - the WIDTH default.
- One natural sub-module: muldiv_sign_fix. It is combinational and does the conditional two's-complement negation of the product, quotient and remainder.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done in cycle 34; HI=0xFFFFFFFE, LO=0x00000001; busy high in cycles 1..33.
- MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Also: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x64 / 0 -> done in cycle 1; HI=0x64, LO=0xFFFFFFFF.
  - With MULDIV_DIVZERO_FLAG_EN: div_zero=1 with done.
- MULTU started with HI/LO=0x11/0x22, flush_i in cycle 10 -> busy=0 in cycle 11; no done; HI/LO stay 0x11/0x22.
  - Also: hilo_rd_i high in cycle 5 -> stall_out=1.
- rst driven low in cycle 20 of a DIVU -> hi_out, lo_out, busy, done = 0 immediately, before the next edge; after release, a new MULTU 3x4 gives LO=12.
